// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller: one shared round-key generator, eleven-entry bank read by index.
// Optional feature: define KEY_SCHED_REUSE_EN to skip re-expansion when the same key is started again.

module aes_key_generation (
  input  logic [3:0]   rc,
  input  logic [127:0] key,
  output logic [127:0] next_key
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [31:0] rot_s;
  logic [31:0] temp_s;
  logic [31:0] w0_s;
  logic [31:0] w1_s;
  logic [31:0] w2_s;
  logic [31:0] w3_s;

  // One expansion round: RotWord, SubWord, Rcon, then the xor chain across the four words
  always_comb begin
    rot_s    = {key[23:0], key[31:24]};
    temp_s   = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])}
               ^ {rcon(rc), 24'h000000};
    w0_s     = key[127:96] ^ temp_s;
    w1_s     = key[95:64]  ^ w0_s;
    w2_s     = key[63:32]  ^ w1_s;
    w3_s     = key[31:0]   ^ w2_s;
    next_key = {w0_s, w1_s, w2_s, w3_s};
  end

endmodule

module aes_key_sched_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         rd_err
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [3:0]     cnt_r;
  logic [3:0]     cnt_s;
  logic           busy_r;
  logic           busy_s;
  logic           done_r;
  logic           done_s;
  logic           valid_r;
  logic           valid_s;
  logic           load_key_s;
  logic           expand_we_s;
  logic           reuse_hit_s;
  logic           rd_ok_s;
  logic [127:0]   cur_key_s;
  logic [127:0]   kg_key_s;
  logic [127:0]   rd_data_s;
  logic [127:0]   rd_key_r;
  logic           rd_err_r;
  logic [127:0]   rk_r [0:NR];

  aes_key_generation u_key_generation (
    .rc       (cnt_r),
    .key      (cur_key_s),
    .next_key (kg_key_s)
  );

  // Bank muxes: generator source selected by cnt, read data selected by rd_idx
  always_comb begin
    cur_key_s = 128'h0;
    rd_data_s = 128'h0;
    for (int i = 0; i <= NR; i++) begin
      cur_key_s = (cnt_r  == 4'(i)) ? rk_r[i] : cur_key_s;
      rd_data_s = (rd_idx == 4'(i)) ? rk_r[i] : rd_data_s;
    end
    rd_ok_s = (rd_idx <= LAST_IDX) && valid_r;
  end

`ifdef KEY_SCHED_REUSE_EN
  // Same key as the schedule already held: nothing to expand
  always_comb begin
    reuse_hit_s = valid_r && (key_in == rk_r[0]);
  end
`else
  // No comparator: every accepted start expands
  always_comb begin
    reuse_hit_s = 1'b0;
  end
`endif

  // Next-state and next-output decode
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    valid_s     = valid_r;
    load_key_s  = 1'b0;
    expand_we_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && reuse_hit_s) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          valid_s = 1'b1;
        end else if (start) begin
          state_s    = ST_EXPAND;
          cnt_s      = 4'd0;
          busy_s     = 1'b1;
          valid_s    = 1'b0;
          load_key_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXPAND: begin
        expand_we_s = 1'b1;
        cnt_s       = cnt_r + 4'd1;
        if (cnt_r == (LAST_IDX - 4'd1)) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else begin
          busy_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        valid_s = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
        valid_s = 1'b0;
      end
    endcase
  end

  // Control state and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      valid_r <= valid_s;
    end
  end

  // Round-key bank: rk[0] from the captured key, rk[cnt+1] from the generator
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) begin
        rk_r[i] <= 128'h0;
      end
    end else if (load_key_s) begin
      rk_r[0] <= key_in;
    end else if (expand_we_s) begin
      for (int i = 1; i <= NR; i++) begin
        if (cnt_r == 4'(i - 1)) begin
          rk_r[i] <= kg_key_s;
        end
      end
    end
  end

  // Registered read port; uses the pre-edge keys_valid so a same-cycle start still sees the old schedule
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key_r <= 128'h0;
      rd_err_r <= 1'b0;
    end else if (rd_en && rd_ok_s) begin
      rd_key_r <= rd_data_s;
      rd_err_r <= 1'b0;
    end else if (rd_en) begin
      rd_key_r <= 128'h0;
      rd_err_r <= 1'b1;
    end else begin
      rd_err_r <= 1'b0;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign keys_valid = valid_r;
  assign rd_key     = rd_key_r;
  assign rd_err     = rd_err_r;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed self-checking bench for aes_key_sched_ctrl using FIPS-197 key schedules.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         rd_err;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] fips_rk [0:10];
  logic [127:0] c1_key;
  logic [127:0] c1_rk1;
  logic [127:0] c1_rk10;

  aes_key_sched_ctrl #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .rd_err     (rd_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_key(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; rd_en = 1'b0; rd_idx = 4'd0; key_in = 128'h0;
    tick(); tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", keys_valid); end
    vectors++; if (rd_err !== 1'b0) begin miscompares++; $display("FAIL reset_rd_err: got %b want 0", rd_err); end
    vectors++; if (rd_key !== 128'h0) begin miscompares++; $display("FAIL reset_rd_key: got %h want 0", rd_key); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_before_done;
    rd_en = 1'b1; rd_idx = 4'd0;
    tick();
    vectors++; if (rd_err !== 1'b1) begin miscompares++; $display("FAIL early_rd_err: got %b want 1", rd_err); end
    vectors++; if (rd_key !== 128'h0) begin miscompares++; $display("FAIL early_rd_key: got %h want 0", rd_key); end
    rd_en = 1'b0;
    tick();
    vectors++; if (rd_err !== 1'b0) begin miscompares++; $display("FAIL idle_rd_err: got %b want 0", rd_err); end
  endtask

  task automatic test_fips_expand;
    start_key(fips_rk[0]);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL e0_busy: got %b want 1", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL e0_done: got %b want 0", done); end
    vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL e0_valid: got %b want 0", keys_valid); end
    rd_en = 1'b1; rd_idx = 4'd0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      rd_en = 1'b0;
      if (e == 1) begin
        vectors++; if (rd_err !== 1'b1) begin miscompares++; $display("FAIL busy_rd_err: got %b want 1", rd_err); end
      end
      vectors++; if (busy !== (e < 10)) begin miscompares++; $display("FAIL e%0d_busy: got %b want %b", e, busy, (e < 10)); end
      vectors++; if (done !== (e == 10)) begin miscompares++; $display("FAIL e%0d_done: got %b want %b", e, done, (e == 10)); end
    end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL e11_done: got %b want 0", done); end
    vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL e11_valid: got %b want 1", keys_valid); end
    rd_en = 1'b1; rd_idx = 4'd10;
    tick();
    vectors++; if (rd_key !== fips_rk[10]) begin miscompares++; $display("FAIL fips_rk10: got %h want %h", rd_key, fips_rk[10]); end
    rd_idx = 4'd1;
    tick();
    vectors++; if (rd_key !== fips_rk[1]) begin miscompares++; $display("FAIL fips_rk1: got %h want %h", rd_key, fips_rk[1]); end
    vectors++; if (rd_err !== 1'b0) begin miscompares++; $display("FAIL fips_rd_err: got %b want 0", rd_err); end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_inverse_sweep;
    rd_en = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      rd_idx = 4'(i);
      tick();
      vectors++; if (rd_key !== fips_rk[i]) begin miscompares++; $display("FAIL sweep_rk%0d: got %h want %h", i, rd_key, fips_rk[i]); end
      vectors++; if (rd_err !== 1'b0) begin miscompares++; $display("FAIL sweep_err%0d: got %b want 0", i, rd_err); end
    end
    rd_en = 1'b0; rd_idx = 4'd3;
    tick();
    vectors++; if (rd_key !== fips_rk[0]) begin miscompares++; $display("FAIL hold_rd_key: got %h want %h", rd_key, fips_rk[0]); end
    vectors++; if (rd_err !== 1'b0) begin miscompares++; $display("FAIL hold_rd_err: got %b want 0", rd_err); end
  endtask

  task automatic test_error_reads;
    rd_en = 1'b1; rd_idx = 4'd11;
    tick();
    vectors++; if (rd_err !== 1'b1) begin miscompares++; $display("FAIL idx11_err: got %b want 1", rd_err); end
    vectors++; if (rd_key !== 128'h0) begin miscompares++; $display("FAIL idx11_key: got %h want 0", rd_key); end
    rd_idx = 4'd15;
    tick();
    vectors++; if (rd_err !== 1'b1) begin miscompares++; $display("FAIL idx15_err: got %b want 1", rd_err); end
    vectors++; if (rd_key !== 128'h0) begin miscompares++; $display("FAIL idx15_key: got %h want 0", rd_key); end
    rd_idx = 4'd10;
    tick();
    vectors++; if (rd_err !== 1'b0) begin miscompares++; $display("FAIL idx10_err: got %b want 0", rd_err); end
    vectors++; if (rd_key !== fips_rk[10]) begin miscompares++; $display("FAIL idx10_key: got %h want %h", rd_key, fips_rk[10]); end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_start_while_busy;
    start_key(fips_rk[0]);
    tick(); tick();
    key_in = c1_key; start = 1'b1;
    tick();
    start = 1'b0; key_in = 128'h0;
    for (int e = 4; e <= 10; e++) tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL busy_start_done: got %b want 1", done); end
    tick();
    vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL busy_start_valid: got %b want 1", keys_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_start_rearm: got %b want 0", busy); end
    rd_en = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i);
      tick();
      vectors++; if (rd_key !== fips_rk[i]) begin miscompares++; $display("FAIL busy_start_rk%0d: got %h want %h", i, rd_key, fips_rk[i]); end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_read_start_same_cycle;
    rd_en = 1'b1; rd_idx = 4'd10; key_in = c1_key; start = 1'b1;
    tick();
    start = 1'b0; rd_en = 1'b0;
    vectors++; if (rd_key !== fips_rk[10]) begin miscompares++; $display("FAIL same_cyc_key: got %h want %h", rd_key, fips_rk[10]); end
    vectors++; if (rd_err !== 1'b0) begin miscompares++; $display("FAIL same_cyc_err: got %b want 0", rd_err); end
    vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL same_cyc_valid: got %b want 0", keys_valid); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL same_cyc_busy: got %b want 1", busy); end
    for (int e = 1; e <= 11; e++) tick();
    vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL c1_valid: got %b want 1", keys_valid); end
    rd_en = 1'b1; rd_idx = 4'd1;
    tick();
    vectors++; if (rd_key !== c1_rk1) begin miscompares++; $display("FAIL c1_rk1: got %h want %h", rd_key, c1_rk1); end
    rd_idx = 4'd10;
    tick();
    vectors++; if (rd_key !== c1_rk10) begin miscompares++; $display("FAIL c1_rk10: got %h want %h", rd_key, c1_rk10); end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reuse;
    start_key(fips_rk[0]);
    for (int e = 1; e <= 11; e++) tick();
    start_key(fips_rk[0]);
`ifdef KEY_SCHED_REUSE_EN
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reuse_e0_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL reuse_e0_done: got %b want 1", done); end
    vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL reuse_e0_valid: got %b want 1", keys_valid); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reuse_e1_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reuse_e1_done: got %b want 0", done); end
    vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL reuse_e1_valid: got %b want 1", keys_valid); end
`else
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL repeat_e0_busy: got %b want 1", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL repeat_e0_done: got %b want 0", done); end
    for (int e = 1; e <= 10; e++) tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL repeat_e10_done: got %b want 1", done); end
    tick();
`endif
    rd_en = 1'b1; rd_idx = 4'd10;
    tick();
    rd_en = 1'b0;
    vectors++; if (rd_key !== fips_rk[10]) begin miscompares++; $display("FAIL repeat_rk10: got %h want %h", rd_key, fips_rk[10]); end
    start_key(c1_key);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL newkey_e0_busy: got %b want 1", busy); end
    for (int e = 1; e <= 10; e++) tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL newkey_e10_done: got %b want 1", done); end
    tick();
    vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL newkey_valid: got %b want 1", keys_valid); end
  endtask

  task automatic test_reset_mid;
    start_key(fips_rk[0]);
    for (int e = 1; e <= 4; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", keys_valid); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_done: got %b want 0", done); end
    vectors++; if (rd_key !== 128'h0) begin miscompares++; $display("FAIL mid_rst_key: got %h want 0", rd_key); end
    rd_en = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i);
      tick();
      vectors++; if (rd_err !== 1'b1) begin miscompares++; $display("FAIL mid_rst_rd%0d_err: got %b want 1", i, rd_err); end
    end
    rd_en = 1'b0;
    start_key(c1_key);
    for (int e = 1; e <= 10; e++) tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL post_rst_done: got %b want 1", done); end
    tick();
    vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL post_rst_valid: got %b want 1", keys_valid); end
    rd_en = 1'b1; rd_idx = 4'd10;
    tick();
    vectors++; if (rd_key !== c1_rk10) begin miscompares++; $display("FAIL post_rst_rk10: got %h want %h", rd_key, c1_rk10); end
    rd_idx = 4'd0;
    tick();
    vectors++; if (rd_key !== c1_key) begin miscompares++; $display("FAIL post_rst_rk0: got %h want %h", rd_key, c1_key); end
    rd_en = 1'b0;
    tick();
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    c1_key      = 128'h000102030405060708090a0b0c0d0e0f;
    c1_rk1      = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    c1_rk10     = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    test_reset();
    test_read_before_done();
    test_fips_expand();
    test_inverse_sweep();
    test_error_reads();
    test_start_while_busy();
    test_read_start_same_cycle();
    test_reuse();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
